alu_seq: RTL and testbench

//  Two-pass nibble sequencer for the 8-bit ALU block. Accepts one arithmetic/logic op with two
//  8-bit operands and drives the ALU control wires: OP1 load, then low nibble (with OP2 load),

---
 rtl/alu_seq_pkg.sv | 71 +++++++
 rtl/alu_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: operation, bus-select and state encodings for the ALU nibble
// sequencer, the per-operation core control table and the F register bit map.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CP  = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    BUS_HIGHZ = 3'd0,
    BUS_SHIFT = 3'd1,
    BUS_RES   = 3'd2,
    BUS_BS    = 3'd3
  } bus_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Core function select: R = AND, S = OR, V = XOR, all clear = adder
  typedef struct packed {
    logic r;
    logic s;
    logic v;
  } core_rsv_t;

  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_X  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  function automatic core_rsv_t core_rsv(alu_op_t op);
    case (op)
      OP_AND:  return '{r: 1'b1, s: 1'b0, v: 1'b0};
      OP_OR:   return '{r: 1'b0, s: 1'b1, v: 1'b0};
      OP_XOR:  return '{r: 1'b0, s: 1'b0, v: 1'b1};
      default: return '{r: 1'b0, s: 1'b0, v: 1'b0};
    endcase
  endfunction

  // Subtract-class ops feed the inverted operand into the adder
  function automatic logic op_is_sub(alu_op_t op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  // Carry into the low nibble; subtraction is a + ~b + 1, SBC folds the borrow in
  function automatic logic cin0(alu_op_t op, logic cin);
    case (op)
      OP_ADC:        return cin;
      OP_SUB, OP_CP: return 1'b1;
      OP_SBC:        return ~cin;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: two-pass nibble sequencer for the 8-bit ALU. Loads OP1, runs the low
// nibble (loading OP2), then the high nibble, and assembles the Z80 F register.
// Optional build macro ALU_SEQ_CP_XY_EN: for CP, the Y/X flags copy op2[5]/op2[3]
// instead of result[5]/result[3].
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic       carry_in,
  output logic [7:0] alu_db_out,
  output logic       alu_db_oe,
  input  logic [7:0] alu_db_in,
  output logic [2:0] bus_sel,
  output logic       alu_op1_sel_bus,
  output logic       alu_op2_sel_bus,
  output logic       alu_op_low,
  output logic       alu_sel_op2_high,
  output logic       alu_sel_op2_neg,
  output logic       alu_core_cf_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  output logic       alu_parity_in,
  input  logic       alu_core_cf_out,
  input  logic       alu_vf_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero,
  input  logic       alu_sf_out,
  output logic       done,
  output logic [7:0] result,
  output logic       result_we,
  output logic [7:0] flags
);

  state_t    state_q, state_d;
  alu_op_t   op_q, op_d;
  logic [7:0] op2_q, op2_d;
  logic      cin_q, cin_d;
  logic      hc_q, hc_d, pf_q, pf_d, zlo_q, zlo_d;
  logic      ready_q, ready_d;
  logic [7:0] db_q, db_d;
  logic      oe_q, oe_d;
  bus_t      bus_q, bus_d;
  logic      op1_sel_q, op1_sel_d, op2_sel_q, op2_sel_d;
  logic      low_q, low_d, high_q, high_d, neg_q, neg_d;
  logic      cfin_q, cfin_d, pin_q, pin_d;
  core_rsv_t rsv_q, rsv_d;
  logic      done_q, done_d, we_q, we_d;
  logic [7:0] result_q, result_d, flags_q, flags_d, flags_asm;
  logic      accept;

  assign accept = op_valid & ready_q;

  // Assemble F from the live high-nibble status and the latched low-nibble status
  always_comb begin
    flags_asm         = '0;
    flags_asm[FLAG_S] = alu_sf_out;
    flags_asm[FLAG_Z] = zlo_q & alu_zero;
    flags_asm[FLAG_Y] = alu_db_in[5];
    flags_asm[FLAG_X] = alu_db_in[3];
`ifdef ALU_SEQ_CP_XY_EN
    if (op_q == OP_CP) begin
      flags_asm[FLAG_Y] = op2_q[5];
      flags_asm[FLAG_X] = op2_q[3];
    end
`endif
    case (op_q)
      OP_ADD, OP_ADC: begin
        flags_asm[FLAG_H]  = hc_q;
        flags_asm[FLAG_C]  = alu_core_cf_out;
        flags_asm[FLAG_PV] = alu_vf_out;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // Adder carries mean "no borrow"; Z80 H/C report the borrow
        flags_asm[FLAG_H]  = ~hc_q;
        flags_asm[FLAG_C]  = ~alu_core_cf_out;
        flags_asm[FLAG_PV] = alu_vf_out;
        flags_asm[FLAG_N]  = 1'b1;
      end
      OP_AND: begin
        flags_asm[FLAG_H]  = 1'b1;
        flags_asm[FLAG_PV] = alu_parity_out;
      end
      default: begin
        flags_asm[FLAG_PV] = alu_parity_out;
      end
    endcase
  end

  // Next state, captured operands/status, and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    op2_d    = op2_q;
    cin_d    = cin_q;
    hc_d     = hc_q;
    pf_d     = pf_q;
    zlo_d    = zlo_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_OP1;
          op_d    = alu_op_t'(op_code);
          op2_d   = op2;
          cin_d   = carry_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OP1: state_d = ST_LOW;
      ST_LOW: begin
        state_d = ST_HIGH;
        hc_d    = alu_core_cf_out;
        pf_d    = alu_parity_out;
        zlo_d   = alu_zero;
      end
      ST_HIGH: begin
        state_d  = ST_DONE;
        result_d = alu_db_in;
        flags_d  = flags_asm;
        done_d   = 1'b1;
        we_d     = (op_q != OP_CP);
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d   = 1'b0;
    db_d      = '0;
    oe_d      = 1'b0;
    bus_d     = BUS_HIGHZ;
    op1_sel_d = 1'b0;
    op2_sel_d = 1'b0;
    low_d     = 1'b0;
    high_d    = 1'b0;
    neg_d     = 1'b0;
    cfin_d    = 1'b0;
    pin_d     = 1'b0;
    rsv_d     = '0;
    case (state_d)
      ST_IDLE, ST_DONE: ready_d = 1'b1;
      ST_OP1: begin
        // OP1 is only entered on accept, so the live op1 input is the operand
        db_d      = op1;
        oe_d      = 1'b1;
        bus_d     = BUS_SHIFT;
        op1_sel_d = 1'b1;
      end
      ST_LOW: begin
        db_d      = op2_d;
        oe_d      = 1'b1;
        bus_d     = BUS_SHIFT;
        op2_sel_d = 1'b1;
        low_d     = 1'b1;
        neg_d     = op_is_sub(op_d);
        cfin_d    = cin0(op_d, cin_d);
        rsv_d     = core_rsv(op_d);
      end
      ST_HIGH: begin
        bus_d  = BUS_RES;
        high_d = 1'b1;
        neg_d  = op_is_sub(op_d);
        cfin_d = hc_d;
        pin_d  = pf_d;
        rsv_d  = core_rsv(op_d);
      end
      default: ;
    endcase
  end

  // All sequencer state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      op2_q     <= '0;
      cin_q     <= 1'b0;
      hc_q      <= 1'b0;
      pf_q      <= 1'b0;
      zlo_q     <= 1'b0;
      ready_q   <= 1'b1;
      db_q      <= '0;
      oe_q      <= 1'b0;
      bus_q     <= BUS_HIGHZ;
      op1_sel_q <= 1'b0;
      op2_sel_q <= 1'b0;
      low_q     <= 1'b0;
      high_q    <= 1'b0;
      neg_q     <= 1'b0;
      cfin_q    <= 1'b0;
      pin_q     <= 1'b0;
      rsv_q     <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op2_q     <= op2_d;
      cin_q     <= cin_d;
      hc_q      <= hc_d;
      pf_q      <= pf_d;
      zlo_q     <= zlo_d;
      ready_q   <= ready_d;
      db_q      <= db_d;
      oe_q      <= oe_d;
      bus_q     <= bus_d;
      op1_sel_q <= op1_sel_d;
      op2_sel_q <= op2_sel_d;
      low_q     <= low_d;
      high_q    <= high_d;
      neg_q     <= neg_d;
      cfin_q    <= cfin_d;
      pin_q     <= pin_d;
      rsv_q     <= rsv_d;
      done_q    <= done_d;
      we_q      <= we_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign op_ready         = ready_q;
  assign alu_db_out       = db_q;
  assign alu_db_oe        = oe_q;
  assign bus_sel          = bus_q;
  assign alu_op1_sel_bus  = op1_sel_q;
  assign alu_op2_sel_bus  = op2_sel_q;
  assign alu_op_low       = low_q;
  assign alu_sel_op2_high = high_q;
  assign alu_sel_op2_neg  = neg_q;
  assign alu_core_cf_in   = cfin_q;
  assign alu_core_R       = rsv_q.r;
  assign alu_core_S       = rsv_q.s;
  assign alu_core_V       = rsv_q.v;
  assign alu_parity_in    = pin_q;
  assign done             = done_q;
  assign result           = result_q;
  assign result_we        = we_q;
  assign flags            = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: bench for alu_seq with a behavioural 4-bit ALU core attached and an
// 8-bit Z80 reference feeding a result/flags scoreboard. Honours ALU_SEQ_CP_XY_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_code = 3'd0;
  logic [7:0] op1 = 8'h00, op2 = 8'h00;
  logic       carry_in = 1'b0;
  logic [7:0] alu_db_out, alu_db_in;
  logic       alu_db_oe;
  logic [2:0] bus_sel;
  logic alu_op1_sel_bus, alu_op2_sel_bus, alu_op_low, alu_sel_op2_high, alu_sel_op2_neg;
  logic alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in;
  logic alu_core_cf_out, alu_vf_out, alu_parity_out, alu_zero, alu_sf_out;
  logic       done, result_we;
  logic [7:0] result, flags;

  alu_seq dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op1(op1), .op2(op2), .carry_in(carry_in),
    .alu_db_out(alu_db_out), .alu_db_oe(alu_db_oe), .alu_db_in(alu_db_in),
    .bus_sel(bus_sel), .alu_op1_sel_bus(alu_op1_sel_bus), .alu_op2_sel_bus(alu_op2_sel_bus),
    .alu_op_low(alu_op_low), .alu_sel_op2_high(alu_sel_op2_high),
    .alu_sel_op2_neg(alu_sel_op2_neg), .alu_core_cf_in(alu_core_cf_in),
    .alu_core_R(alu_core_R), .alu_core_S(alu_core_S), .alu_core_V(alu_core_V),
    .alu_parity_in(alu_parity_in), .alu_core_cf_out(alu_core_cf_out),
    .alu_vf_out(alu_vf_out), .alu_parity_out(alu_parity_out), .alu_zero(alu_zero),
    .alu_sf_out(alu_sf_out), .done(done), .result(result), .result_we(result_we),
    .flags(flags)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural nibble ALU ----------------
  logic [7:0] m_op1 = 8'h00, m_op2 = 8'h00;
  logic [3:0] m_lo = 4'h0;
  logic [3:0] m_a, m_b, m_nib;
  logic [7:0] m_bsrc;
  logic [4:0] m_sum;
  logic [3:0] m_lo3;
  logic       m_arith;

  always @(posedge clk) begin
    if (alu_op1_sel_bus) m_op1 <= alu_db_out;
    if (alu_op2_sel_bus) m_op2 <= alu_db_out;
    if (alu_op_low)      m_lo  <= m_nib;
  end

  always_comb begin
    m_a    = alu_op_low ? m_op1[3:0] : m_op1[7:4];
    m_bsrc = alu_op2_sel_bus ? alu_db_out : m_op2;
    m_b    = alu_sel_op2_high ? m_bsrc[7:4] : m_bsrc[3:0];
    if (alu_sel_op2_neg) m_b = ~m_b;
    m_sum  = {1'b0, m_a} + {1'b0, m_b} + {4'b0, alu_core_cf_in};
    m_lo3  = {1'b0, m_a[2:0]} + {1'b0, m_b[2:0]} + {3'b0, alu_core_cf_in};
    m_arith = !(alu_core_R || alu_core_S || alu_core_V);
    if (alu_core_R)      m_nib = m_a & m_b;
    else if (alu_core_S) m_nib = m_a | m_b;
    else if (alu_core_V) m_nib = m_a ^ m_b;
    else                 m_nib = m_sum[3:0];
    alu_core_cf_out = m_arith & m_sum[4];
    alu_vf_out      = m_arith & (m_lo3[3] ^ m_sum[4]);
    alu_zero        = (m_nib == 4'h0);
    alu_sf_out      = m_nib[3];
    alu_parity_out  = alu_op_low ? (^m_nib) : ~(alu_parity_in ^ (^m_nib));
    alu_db_in       = alu_db_oe ? 8'h00 : {m_nib, m_lo};
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [7:0] res;
    logic [7:0] flg;
    logic       we;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t ref_op(alu_op_t op, logic [7:0] a, logic [7:0] b, logic cin);
    exp_t e;
    int ia, ib, ic, t;
    logic [7:0] r;
    logic h, c, v, n, pv, yb, xb;
    ia = int'(a); ib = int'(b); ic = 0;
    h = 1'b0; c = 1'b0; v = 1'b0; n = 1'b0; pv = 1'b0; r = 8'h00; t = 0;
    case (op)
      OP_ADD, OP_ADC: begin
        if (op == OP_ADC) ic = cin ? 1 : 0;
        t  = ia + ib + ic;
        r  = t[7:0];
        c  = (t > 255);
        h  = ((ia % 16) + (ib % 16) + ic) > 15;
        v  = (a[7] == b[7]) && (r[7] != a[7]);
        pv = v;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        if (op == OP_SBC) ic = cin ? 1 : 0;
        t  = ia - ib - ic;
        r  = t[7:0];
        c  = (t < 0);
        h  = ((ia % 16) - (ib % 16) - ic) < 0;
        v  = (a[7] != b[7]) && (r[7] != a[7]);
        pv = v;
        n  = 1'b1;
      end
      OP_AND: begin r = a & b; h = 1'b1; pv = ~^r; end
      OP_XOR: begin r = a ^ b; pv = ~^r; end
      default: begin r = a | b; pv = ~^r; end
    endcase
    yb = r[5];
    xb = r[3];
`ifdef ALU_SEQ_CP_XY_EN
    if (op == OP_CP) begin yb = b[5]; xb = b[3]; end
`endif
    e.res = r;
    e.flg = {r[7], (r == 8'h00), yb, h, xb, pv, n, c};
    e.we  = (op != OP_CP);
    return e;
  endfunction

  // Compare every completed operation against the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 with result=%02h and nothing outstanding", result);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (result !== mon_e.res) begin errors++; $display("FAIL result: got %02h want %02h", result, mon_e.res); end
        checks++;
        if (flags !== mon_e.flg) begin errors++; $display("FAIL flags: got %02h want %02h (result %02h)", flags, mon_e.flg, mon_e.res); end
        checks++;
        if (result_we !== mon_e.we) begin errors++; $display("FAIL result_we: got %b want %b", result_we, mon_e.we); end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one op; returns #1 after the edge that accepts it, with op_valid dropped
  task automatic send(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    op_code = op; op1 = a; op2 = b; carry_in = cin; op_valid = 1'b1;
    sb_q.push_back(ref_op(op, a, b, cin));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [9:0] ctrl_vec;
  assign ctrl_vec = {alu_op1_sel_bus, alu_op2_sel_bus, alu_op_low, alu_sel_op2_high,
                     alu_sel_op2_neg, alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V,
                     alu_parity_in};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({alu_db_oe, alu_db_out} !== 9'h000) begin errors++; $display("FAIL reset_db: got oe=%b db=%02h want 0/00", alu_db_oe, alu_db_out); end
    checks++; if (bus_sel !== BUS_HIGHZ) begin errors++; $display("FAIL reset_bus_sel: got %0d want %0d", bus_sel, BUS_HIGHZ); end
    checks++; if (ctrl_vec !== 10'h000) begin errors++; $display("FAIL reset_ctrl: got %03h want 000", ctrl_vec); end
    checks++; if ({result, flags, result_we} !== 17'h0) begin errors++; $display("FAIL reset_result: got %02h/%02h/%b want 00/00/0", result, flags, result_we); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    send(OP_ADD, 8'h8C, 8'h6D, 1'b0);
    // OP1 cycle
    checks++; if ({op_ready, alu_db_oe, alu_op1_sel_bus} !== 3'b011) begin errors++; $display("FAIL add_op1_ctrl: got ready/oe/sel=%b%b%b want 011", op_ready, alu_db_oe, alu_op1_sel_bus); end
    checks++; if (alu_db_out !== 8'h8C || bus_sel !== BUS_SHIFT) begin errors++; $display("FAIL add_op1_db: got %02h bus %0d want 8c bus %0d", alu_db_out, bus_sel, BUS_SHIFT); end
    @(posedge clk); #1;
    // LOW cycle
    checks++; if (alu_db_out !== 8'h6D) begin errors++; $display("FAIL add_low_db: got %02h want 6d", alu_db_out); end
    checks++; if ({alu_op2_sel_bus, alu_op_low, alu_sel_op2_high, alu_sel_op2_neg, alu_core_cf_in} !== 5'b11000) begin errors++; $display("FAIL add_low_ctrl: got %b want 11000", {alu_op2_sel_bus, alu_op_low, alu_sel_op2_high, alu_sel_op2_neg, alu_core_cf_in}); end
    @(posedge clk); #1;
    // HIGH cycle: C+D carries out of the low nibble
    checks++; if ({alu_db_oe, alu_sel_op2_high, alu_core_cf_in, alu_op_low} !== 4'b0110) begin errors++; $display("FAIL add_high_ctrl: got oe/high/cf/low=%b want 0110", {alu_db_oe, alu_sel_op2_high, alu_core_cf_in, alu_op_low}); end
    checks++; if (bus_sel !== BUS_RES) begin errors++; $display("FAIL add_high_bus: got %0d want %0d", bus_sel, BUS_RES); end
    @(posedge clk); #1;
    checks++; if ({done, op_ready} !== 2'b11) begin errors++; $display("FAIL add_done_timing: got done/ready=%b%b want 11 on fourth cycle", done, op_ready); end
    @(posedge clk); #1;
    checks++; if ({done, op_ready} !== 2'b01) begin errors++; $display("FAIL add_done_pulse: got done/ready=%b%b want 01", done, op_ready); end
  endtask

  task automatic test_sub();
    int lat;
    send(OP_SUB, 8'h10, 8'h01, 1'b0);
    @(posedge clk); #1;
    checks++; if ({alu_sel_op2_neg, alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V} !== 5'b11000) begin errors++; $display("FAIL sub_low_ctrl: got neg/cf/R/S/V=%b want 11000", {alu_sel_op2_neg, alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V}); end
    wait_done(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL sub_latency: got %0d more edges want 2", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    int lat;
    alu_op_t ops [4] = '{OP_AND, OP_XOR, OP_OR, OP_OR};
    logic [7:0] av [4] = '{8'hF0, 8'h5A, 8'h00, 8'h81};
    logic [7:0] bv [4] = '{8'h0F, 8'hFF, 8'h00, 8'h02};
    logic [2:0] rsv_w [4] = '{3'b100, 3'b001, 3'b010, 3'b010};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], av[i], bv[i], 1'b1);
      @(posedge clk); #1;
      checks++; if ({alu_core_R, alu_core_S, alu_core_V} !== rsv_w[i] || alu_sel_op2_neg !== 1'b0) begin errors++; $display("FAIL logic_rsv[%0d]: got RSV=%b neg=%b want %b/0", i, {alu_core_R, alu_core_S, alu_core_V}, alu_sel_op2_neg, rsv_w[i]); end
      wait_done(lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL logic_latency[%0d]: got %0d want 2", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith_edges();
    int lat;
    alu_op_t ops [3] = '{OP_CP, OP_ADC, OP_SBC};
    logic [7:0] av [3] = '{8'h40, 8'h7F, 8'h00};
    logic [7:0] bv [3] = '{8'h28, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], av[i], bv[i], 1'b1);
      wait_done(lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL arith_latency[%0d]: got %0d want 3", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    send(OP_SUB, 8'h33, 8'h11, 1'b0);
    @(posedge clk); #1;
    checks++; if (alu_op_low !== 1'b1) begin errors++; $display("FAIL mid_in_low: got op_low=%b want 1", alu_op_low); end
    #2 reset = 1'b1;
    #1;
    void'(sb_q.pop_back());
    checks++; if ({op_ready, done, alu_db_oe} !== 3'b100 || alu_db_out !== 8'h00) begin errors++; $display("FAIL mid_reset_out: got ready/done/oe=%b db=%02h want 100/00", {op_ready, done, alu_db_oe}, alu_db_out); end
    checks++; if (ctrl_vec !== 10'h000 || bus_sel !== BUS_HIGHZ) begin errors++; $display("FAIL mid_reset_ctrl: got %03h bus %0d want 000 bus 0", ctrl_vec, bus_sel); end
    checks++; if ({result, flags} !== 16'h0000) begin errors++; $display("FAIL mid_reset_result: got %02h/%02h want 00/00", result, flags); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses want 0", seen); end
    send(OP_ADD, 8'h01, 8'h01, 1'b0);
    wait_done(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL mid_next_latency: got %0d want 3", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int edge_a, edge_b;
    @(negedge clk);
    op_code = OP_ADC; op1 = 8'h80; op2 = 8'h80; carry_in = 1'b1; op_valid = 1'b1;
    sb_q.push_back(ref_op(OP_ADC, 8'h80, 8'h80, 1'b1));
    @(posedge clk); #1;
    // Held request with new operands; ignored until the sequencer is ready again
    op1 = 8'h00; op2 = 8'h00; carry_in = 1'b0;
    sb_q.push_back(ref_op(OP_ADC, 8'h00, 8'h00, 1'b0));
    edge_a = -1; edge_b = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        op_valid = 1'b0;
        checks++; if ({op_ready, alu_op1_sel_bus} !== 2'b01 || alu_db_out !== 8'h00) begin errors++; $display("FAIL b2b_second_op1: got ready/sel=%b db=%02h want 01/00", {op_ready, alu_op1_sel_bus}, alu_db_out); end
      end
      if (done === 1'b1) begin
        if (edge_a < 0) edge_a = k;
        else if (edge_b < 0) edge_b = k;
      end
    end
    checks++; if (edge_a != 3 || edge_b != 7) begin errors++; $display("FAIL b2b_done_edges: got %0d,%0d want 3,7", edge_a, edge_b); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_arith_edges();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d outstanding want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
